// File: rtl/io_energy_monitor_pkg.sv
// ============================================================================
// Module : io_energy_pkg
// Brief  : Shared types and helpers for the I/O energy monitor: FSM state
//          encoding and a generic saturating adder.
// Config : IO_ENERGY_ZERO_SKIP_EN (not used here; see io_energy_monitor)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_energy_pkg;

  // Monitor FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest operand sat_add supports; callers zero-extend narrower values.
  localparam int unsigned SAT_MAX_WIDTH = 64;

  typedef struct packed {
    logic                     ovf;
    logic [SAT_MAX_WIDTH-1:0] sum;
  } sat_res_t;

  // Adds a and b one bit wider than the operands, then clamps the result to
  // the all-ones value of a 'width'-bit register. ovf flags that clamping
  // happened, i.e. the true sum would not fit in 'width' bits.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_WIDTH-1:0] a,
                                       input logic [SAT_MAX_WIDTH-1:0] b,
                                       input int unsigned              width);
    logic [SAT_MAX_WIDTH:0] full;
    logic [SAT_MAX_WIDTH:0] max;
    sat_res_t               r;
    full = {1'b0, a} + {1'b0, b};
    if (width >= SAT_MAX_WIDTH) begin
      max = {1'b0, {SAT_MAX_WIDTH{1'b1}}};
    end else begin
      max = ({{SAT_MAX_WIDTH{1'b0}}, 1'b1} << width) - {{SAT_MAX_WIDTH{1'b0}}, 1'b1};
    end
    if (full > max) begin
      r.ovf = 1'b1;
      r.sum = max[SAT_MAX_WIDTH-1:0];
    end else begin
      r.ovf = 1'b0;
      r.sum = full[SAT_MAX_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_energy_monitor_if.sv
// ============================================================================
// Module : io_energy_monitor_if
// Brief  : Bundle of the observed accelerator I/O streams.
//          master : the side that produces the stream values (top level / TB)
//          slave  : the passive monitor, all signals are inputs
// Ports  : in_data [NB_IN*DATA_WIDTH], in_valid/in_ready [NB_IN],
//          out_data [DATA_WIDTH], out_valid
// Config : IO_ENERGY_ZERO_SKIP_EN (not used here)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_energy_monitor_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NB_IN      = 2
);

  logic [NB_IN*DATA_WIDTH-1:0] in_data;
  logic [NB_IN-1:0]            in_valid;
  logic [NB_IN-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_valid;

  modport master (
    output in_data, in_valid, in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_ready, out_data, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/io_energy_monitor_port_counter.sv
// ============================================================================
// Module : io_port_counter
// Brief  : Per-input-port transfer and zero-transfer counters with saturation.
// Ports  : clk, arst_n        clock, async active-low reset
//          clear_i            zero both counters (window start)
//          count_en_i         count this edge (monitor in RUN)
//          data_i/valid_i/ready_i  observed port
//          xfer_cnt_o/zero_cnt_o   counters
//          charge_o           this edge's transfer is to be charged energy
//          ovf_o              a counter tried to go past all-ones this edge
// Config : IO_ENERGY_ZERO_SKIP_EN - zero-valued transfers are not charged
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_port_counter
  import io_energy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  wire logic                  clk,
  input  wire logic                  arst_n,
  input  wire logic                  clear_i,
  input  wire logic                  count_en_i,
  input  wire logic [DATA_WIDTH-1:0] data_i,
  input  wire logic                  valid_i,
  input  wire logic                  ready_i,
  output logic      [CNT_WIDTH-1:0]  xfer_cnt_o,
  output logic      [CNT_WIDTH-1:0]  zero_cnt_o,
  output logic                       charge_o,
  output logic                       ovf_o
);

  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_WIDTH-1:0] zero_cnt_q, zero_cnt_d;
  logic                 xfer;
  logic                 is_zero;
  sat_res_t             xfer_res;
  sat_res_t             zero_res;
  logic                 unused_res;

  assign xfer    = valid_i & ready_i;
  assign is_zero = (data_i == '0);

`ifdef IO_ENERGY_ZERO_SKIP_EN
  assign charge_o = count_en_i & xfer & ~is_zero;
`else
  assign charge_o = count_en_i & xfer;
`endif

  assign xfer_res = sat_add(SAT_MAX_WIDTH'(xfer_cnt_q), SAT_MAX_WIDTH'(1), CNT_WIDTH);
  assign zero_res = sat_add(SAT_MAX_WIDTH'(zero_cnt_q), SAT_MAX_WIDTH'(1), CNT_WIDTH);

  // Only the low CNT_WIDTH bits of the generic adder result are kept.
  assign unused_res = ^{xfer_res, zero_res};

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    zero_cnt_d = zero_cnt_q;
    ovf_o      = 1'b0;
    if (clear_i) begin
      xfer_cnt_d = '0;
      zero_cnt_d = '0;
    end else if (count_en_i && xfer) begin
      xfer_cnt_d = xfer_res.sum[CNT_WIDTH-1:0];
      ovf_o      = xfer_res.ovf;
      if (is_zero) begin
        zero_cnt_d = zero_res.sum[CNT_WIDTH-1:0];
        ovf_o      = xfer_res.ovf | zero_res.ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      xfer_cnt_q <= '0;
      zero_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
  assign zero_cnt_o = zero_cnt_q;

endmodule

`default_nettype wire

// File: rtl/io_energy_monitor.sv
// ============================================================================
// Module : io_energy_monitor
// Brief  : Passive monitor of the accelerator I/O boundary. Inside a
//          start/stop window it counts input/output transfers, zero-valued
//          input transfers and cycles, and accumulates an energy estimate of
//          DATA_WIDTH*COST_PER_BIT units per charged transfer. All counters
//          saturate; overflow is sticky until the next start or reset.
// Ports  : clk, arst_n          clock, async active-low reset
//          start, stop          window control
//          bus (slave)          observed streams
//          running, done        FSM in RUN / DONE
//          in_xfer_cnt, in_zero_cnt [NB_IN*CNT_WIDTH], port i at [i*CW +: CW]
//          out_xfer_cnt, cycle_cnt  [CNT_WIDTH]
//          energy [ENERGY_WIDTH], overflow
// Config : IO_ENERGY_ZERO_SKIP_EN - zero-valued transfers add no energy
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_energy_monitor
  import io_energy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NB_IN        = 2,
  parameter int unsigned COST_PER_BIT = 1,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned ENERGY_WIDTH = 48
) (
  input  wire logic                        clk,
  input  wire logic                        arst_n,
  input  wire logic                        start,
  input  wire logic                        stop,
  io_energy_monitor_if.slave               bus,
  output logic                             running,
  output logic                             done,
  output logic [NB_IN*CNT_WIDTH-1:0]       in_xfer_cnt,
  output logic [NB_IN*CNT_WIDTH-1:0]       in_zero_cnt,
  output logic [CNT_WIDTH-1:0]             out_xfer_cnt,
  output logic [CNT_WIDTH-1:0]             cycle_cnt,
  output logic [ENERGY_WIDTH-1:0]          energy,
  output logic                             overflow
);

  localparam logic [SAT_MAX_WIDTH-1:0] XFER_COST =
      SAT_MAX_WIDTH'(DATA_WIDTH) * SAT_MAX_WIDTH'(COST_PER_BIT);

  state_e                   state_q;
  logic                     running_q;
  logic                     done_q;
  logic                     overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]     out_cnt_q, out_cnt_d;
  logic [CNT_WIDTH-1:0]     cyc_q, cyc_d;
  logic [ENERGY_WIDTH-1:0]  energy_q, energy_d;

  logic                     run;
  logic                     clear;
  logic [NB_IN-1:0]         port_charge;
  logic [NB_IN-1:0]         port_ovf;
  logic                     out_charge;
  logic [3:0]               n_charge;
  logic [SAT_MAX_WIDTH-1:0] e_incr;
  sat_res_t                 out_res;
  sat_res_t                 cyc_res;
  sat_res_t                 en_res;
  logic                     unused_res;

  assign run   = (state_q == ST_RUN);
  // A start while already running is ignored, so only IDLE/DONE clear.
  assign clear = !run && start;

  // --------------------------------------------------------------------------
  // FSM with registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-port counters
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NB_IN; i++) begin : g_port
    io_port_counter #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_port_counter (
      .clk        (clk),
      .arst_n     (arst_n),
      .clear_i    (clear),
      .count_en_i (run),
      .data_i     (bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid_i    (bus.in_valid[i]),
      .ready_i    (bus.in_ready[i]),
      .xfer_cnt_o (in_xfer_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .zero_cnt_o (in_zero_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .charge_o   (port_charge[i]),
      .ovf_o      (port_ovf[i])
    );
  end

  // --------------------------------------------------------------------------
  // Energy: number of charged transfers this edge times the per-word cost
  // --------------------------------------------------------------------------
`ifdef IO_ENERGY_ZERO_SKIP_EN
  assign out_charge = run & bus.out_valid & (|bus.out_data);
`else
  assign out_charge = run & bus.out_valid;
`endif

  // At most NB_IN+1 <= 9 charged transfers per edge, so 4 bits suffice.
  always_comb begin
    n_charge = {3'b000, out_charge};
    for (int i = 0; i < NB_IN; i++) begin
      n_charge = n_charge + {3'b000, port_charge[i]};
    end
  end

  assign e_incr = SAT_MAX_WIDTH'(n_charge) * XFER_COST;

  // The generic adder works one bit wider than the widest register, which
  // covers the ENERGY_WIDTH+1-bit sum needed to detect accumulator overflow.
  assign out_res = sat_add(SAT_MAX_WIDTH'(out_cnt_q), SAT_MAX_WIDTH'(1), CNT_WIDTH);
  assign cyc_res = sat_add(SAT_MAX_WIDTH'(cyc_q), SAT_MAX_WIDTH'(1), CNT_WIDTH);
  assign en_res  = sat_add(SAT_MAX_WIDTH'(energy_q), e_incr, ENERGY_WIDTH);

  assign unused_res = ^{out_res, cyc_res, en_res};

  always_comb begin
    out_cnt_d  = out_cnt_q;
    cyc_d      = cyc_q;
    energy_d   = energy_q;
    overflow_d = overflow_q;
    if (clear) begin
      out_cnt_d  = '0;
      cyc_d      = '0;
      energy_d   = '0;
      overflow_d = 1'b0;
    end else if (run) begin
      cyc_d    = cyc_res.sum[CNT_WIDTH-1:0];
      energy_d = en_res.sum[ENERGY_WIDTH-1:0];
      if (bus.out_valid) begin
        out_cnt_d = out_res.sum[CNT_WIDTH-1:0];
      end
      overflow_d = overflow_q | (|port_ovf) | (bus.out_valid & out_res.ovf)
                 | cyc_res.ovf | en_res.ovf;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_cnt_q  <= '0;
      cyc_q      <= '0;
      energy_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      cyc_q      <= cyc_d;
      energy_q   <= energy_d;
      overflow_q <= overflow_d;
    end
  end

  assign running      = running_q;
  assign done         = done_q;
  assign out_xfer_cnt = out_cnt_q;
  assign cycle_cnt    = cyc_q;
  assign energy       = energy_q;
  assign overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_io_energy_monitor.sv
// ============================================================================
// Module : tb_io_energy_monitor
// Brief  : Self-checking bench for io_energy_monitor. Main instance uses the
//          default parameters; a second instance with CNT_WIDTH=4 exercises
//          counter saturation. Expected energy depends on
//          IO_ENERGY_ZERO_SKIP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_energy_monitor;

`ifdef IO_ENERGY_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk;
  logic arst_n;
  logic start_a, stop_a, start_b, stop_b;

  io_energy_monitor_if #(.DATA_WIDTH(16), .NB_IN(2)) bus_a ();
  io_energy_monitor_if #(.DATA_WIDTH(16), .NB_IN(2)) bus_b ();

  logic        run_a, done_a, ovf_a;
  logic [63:0] ix_a, iz_a;
  logic [31:0] ox_a, cyc_a;
  logic [47:0] en_a;

  logic        run_b, done_b, ovf_b;
  logic [7:0]  ix_b, iz_b;
  logic [3:0]  ox_b, cyc_b;
  logic [47:0] en_b;

  io_energy_monitor #(
    .DATA_WIDTH(16), .NB_IN(2), .COST_PER_BIT(1), .CNT_WIDTH(32), .ENERGY_WIDTH(48)
  ) u_dut_a (
    .clk(clk), .arst_n(arst_n), .start(start_a), .stop(stop_a), .bus(bus_a),
    .running(run_a), .done(done_a), .in_xfer_cnt(ix_a), .in_zero_cnt(iz_a),
    .out_xfer_cnt(ox_a), .cycle_cnt(cyc_a), .energy(en_a), .overflow(ovf_a)
  );

  io_energy_monitor #(
    .DATA_WIDTH(16), .NB_IN(2), .COST_PER_BIT(1), .CNT_WIDTH(4), .ENERGY_WIDTH(48)
  ) u_dut_b (
    .clk(clk), .arst_n(arst_n), .start(start_b), .stop(stop_b), .bus(bus_b),
    .running(run_b), .done(done_b), .in_xfer_cnt(ix_b), .in_zero_cnt(iz_b),
    .out_xfer_cnt(ox_b), .cycle_cnt(cyc_b), .energy(en_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          rep;
    logic        start, stop;
    logic [1:0]  iv, ir;
    logic [15:0] d1, d0;
    logic        ov;
    logic [15:0] od;
    logic        e_run, e_done;
    int          e_x0, e_x1, e_z0, e_z1, e_ox, e_cyc;
    longint      e_en;
    logic        e_ovf;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(string nm, int rep, logic st, logic sp, logic [1:0] iv,
                              logic [1:0] ir, logic [15:0] d1, logic [15:0] d0,
                              logic ov, logic [15:0] od, logic e_run, logic e_done,
                              int e_x0, int e_x1, int e_z0, int e_z1, int e_ox,
                              int e_cyc, longint e_en, logic e_ovf);
    vec_t v;
    v.name = nm; v.rep = rep; v.start = st; v.stop = sp; v.iv = iv; v.ir = ir;
    v.d1 = d1; v.d0 = d0; v.ov = ov; v.od = od; v.e_run = e_run; v.e_done = e_done;
    v.e_x0 = e_x0; v.e_x1 = e_x1; v.e_z0 = e_z0; v.e_z1 = e_z1; v.e_ox = e_ox;
    v.e_cyc = e_cyc; v.e_en = e_en; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic st, input logic sp, input logic [1:0] iv,
                         input logic [1:0] ir, input logic [15:0] d1, input logic [15:0] d0,
                         input logic ov, input logic [15:0] od);
    start_a = st; stop_a = sp;
    bus_a.in_valid = iv; bus_a.in_ready = ir; bus_a.in_data = {d1, d0};
    bus_a.out_valid = ov; bus_a.out_data = od;
  endtask

  task automatic check_a(input vec_t v);
    chk({v.name, ".running"}, 64'(run_a), 64'(v.e_run));
    chk({v.name, ".done"}, 64'(done_a), 64'(v.e_done));
    chk({v.name, ".in_xfer0"}, 64'(ix_a[31:0]), 64'(v.e_x0));
    chk({v.name, ".in_xfer1"}, 64'(ix_a[63:32]), 64'(v.e_x1));
    chk({v.name, ".in_zero0"}, 64'(iz_a[31:0]), 64'(v.e_z0));
    chk({v.name, ".in_zero1"}, 64'(iz_a[63:32]), 64'(v.e_z1));
    chk({v.name, ".out_xfer"}, 64'(ox_a), 64'(v.e_ox));
    chk({v.name, ".cycle"}, 64'(cyc_a), 64'(v.e_cyc));
    chk({v.name, ".energy"}, 64'(en_a), 64'(v.e_en));
    chk({v.name, ".overflow"}, 64'(ovf_a), 64'(v.e_ovf));
  endtask

  vec_t tbl[$];

  initial begin
    // name, rep, start, stop, iv, ir, d1, d0, ov, od,
    // run, done, x0, x1, z0, z1, ox, cyc, energy, ovf
    tbl.push_back(mk("reset_idle", 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t1_start", 1, 1, 0, 2'b01, 2'b01, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t1_p0x3", 3, 0, 0, 2'b11, 2'b01, 9, 5, 0, 0, 1, 0, 3, 0, 0, 0, 0, 3, 48, 0));
    tbl.push_back(mk("t1_out", 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 7, 1, 0, 3, 0, 0, 0, 1, 4, 64, 0));
    tbl.push_back(mk("t1_stop", 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 5, 64, 0));
    tbl.push_back(mk("t1_hold", 3, 0, 0, 2'b11, 2'b11, 1, 1, 1, 2, 0, 1, 3, 0, 0, 0, 1, 5, 64, 0));
    tbl.push_back(mk("t2_start", 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t2_zero", 4, 0, 0, 2'b10, 2'b10, 0, 5, 0, 0, 1, 0, 0, 4, 0, 4, 0, 4,
                     ZS ? 0 : 64, 0));
    tbl.push_back(mk("t2_stop", 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 4, 0, 4, 0, 5,
                     ZS ? 0 : 64, 0));
    tbl.push_back(mk("t3_start", 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t3_all", 10, 0, 0, 2'b11, 2'b11, 4, 3, 1, 1, 1, 0, 10, 10, 0, 0, 10, 10, 480, 0));
    tbl.push_back(mk("t3_stop", 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 10, 10, 0, 0, 10, 11, 480, 0));
    tbl.push_back(mk("t6_start", 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t6_p0_outzero", 2, 0, 0, 2'b01, 2'b01, 0, 2, 1, 0, 1, 0, 2, 0, 0, 0, 2, 2,
                     ZS ? 32 : 64, 0));
    tbl.push_back(mk("t6_start_in_run", 1, 1, 0, 2'b01, 2'b01, 0, 2, 0, 0, 1, 0, 3, 0, 0, 0, 2, 3,
                     ZS ? 48 : 80, 0));
    tbl.push_back(mk("t6_start_stop", 1, 1, 1, 2'b10, 2'b10, 0, 0, 1, 5, 0, 1, 3, 1, 0, 1, 3, 4,
                     ZS ? 64 : 112, 0));
    tbl.push_back(mk("t6_hold", 2, 0, 0, 2'b11, 2'b11, 3, 3, 1, 3, 0, 1, 3, 1, 0, 1, 3, 4,
                     ZS ? 64 : 112, 0));

    arst_n = 1'b0;
    drive_a(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    start_b = 1'b0; stop_b = 1'b0;
    bus_b.in_valid = '0; bus_b.in_ready = '0; bus_b.in_data = '0;
    bus_b.out_valid = 1'b0; bus_b.out_data = '0;

    #3;
    chk("rst.running", 64'(run_a), 64'd0);
    chk("rst.energy", 64'(en_a), 64'd0);
    chk("rst.in_xfer", ix_a, 64'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // Table: drive at a negedge, let rep posedges pass, check at the next negedge.
    foreach (tbl[k]) begin
      drive_a(tbl[k].start, tbl[k].stop, tbl[k].iv, tbl[k].ir, tbl[k].d1, tbl[k].d0,
              tbl[k].ov, tbl[k].od);
      repeat (tbl[k].rep) @(posedge clk);
      @(negedge clk);
      check_a(tbl[k]);
    end

    // Asynchronous reset in the middle of a window, then activity while IDLE.
    drive_a(1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    drive_a(0, 0, 2'b01, 2'b01, 0, 6, 0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t5_pre.in_xfer0", 64'(ix_a[31:0]), 64'd6);
    chk("t5_pre.running", 64'(run_a), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("t5_rst.running", 64'(run_a), 64'd0);
    chk("t5_rst.in_xfer0", 64'(ix_a[31:0]), 64'd0);
    chk("t5_rst.cycle", 64'(cyc_a), 64'd0);
    chk("t5_rst.energy", 64'(en_a), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    drive_a(0, 0, 2'b11, 2'b11, 1, 1, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_idle.running", 64'(run_a), 64'd0);
    chk("t5_idle.done", 64'(done_a), 64'd0);
    chk("t5_idle.in_xfer", ix_a, 64'd0);
    chk("t5_idle.out_xfer", 64'(ox_a), 64'd0);
    chk("t5_idle.energy", 64'(en_a), 64'd0);
    drive_a(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

    // Saturation with 4-bit counters on the second instance.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    bus_b.in_valid = 2'b01; bus_b.in_ready = 2'b01; bus_b.in_data = 32'h0000_0001;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t4_15.in_xfer0", 64'(ix_b[3:0]), 64'd15);
    chk("t4_15.overflow", 64'(ovf_b), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_20.in_xfer0", 64'(ix_b[3:0]), 64'd15);
    chk("t4_20.cycle", 64'(cyc_b), 64'd15);
    chk("t4_20.energy", 64'(en_b), 64'd320);
    chk("t4_20.overflow", 64'(ovf_b), 64'd1);
    bus_b.in_valid = 2'b00;
    stop_b = 1'b1;
    @(negedge clk);
    stop_b = 1'b0;
    chk("t4_stop.done", 64'(done_b), 64'd1);
    chk("t4_stop.overflow", 64'(ovf_b), 64'd1);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("t4_restart.in_xfer0", 64'(ix_b[3:0]), 64'd0);
    chk("t4_restart.cycle", 64'(cyc_b), 64'd0);
    chk("t4_restart.overflow", 64'(ovf_b), 64'd0);
    chk("t4_restart.running", 64'(run_b), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
